// File: rtl/pal_cfg_loader.sv
// Serial configuration loader for a bank of PAL product-term select masks.
// Assembles one NUM_INPUTS-bit mask per term and writes it with a one-hot strobe.
module pal_cfg_loader #(
    parameter int NUM_INPUTS = 5,
    parameter int NUM_TERMS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_start,
    input  logic                  cfg_bit,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic [NUM_INPUTS-1:0] term_sel,
    output logic [NUM_TERMS-1:0]  term_wen,
    output logic                  busy,
    output logic                  cfg_done
);

    localparam int BW = $clog2(NUM_INPUTS + 1);
    localparam int TW = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;

    localparam logic [BW-1:0] BIT_LAST  = BW'(NUM_INPUTS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [TW-1:0] TERM_LAST = TW'(NUM_TERMS - 1);
    localparam logic [TW-1:0] TERM_ONE  = TW'(1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SHIFT  = 3'd1;
    localparam logic [2:0] SETUP  = 3'd2;
    localparam logic [2:0] STROBE = 3'd3;
    localparam logic [2:0] HOLD   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]         term_cnt_q, term_cnt_d;
    logic [NUM_INPUTS-1:0] shift_q, shift_d;
    logic [NUM_TERMS-1:0]  wen_d;
    logic                  accept;

    assign accept = cfg_valid && cfg_ready;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        term_cnt_d = term_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = '0;
                    term_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (accept) begin
                    shift_d[bit_cnt_q] = cfg_bit;
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = SETUP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
            end
            SETUP:  state_d = STROBE;
            STROBE: state_d = HOLD;
            HOLD: begin
                if (term_cnt_q == TERM_LAST) begin
                    state_d = DONE;
                end else begin
                    term_cnt_d = term_cnt_q + TERM_ONE;
                    state_d    = SHIFT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wen_d = '0;
        if (state_d == STROBE) begin
            wen_d[term_cnt_d] = 1'b1;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            term_cnt_q <= '0;
            shift_q    <= '0;
            term_sel   <= '0;
            term_wen   <= '0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            term_cnt_q <= term_cnt_d;
            shift_q    <= shift_d;
            term_wen   <= wen_d;
            cfg_ready  <= (state_d == SHIFT);
            busy       <= (state_d != IDLE);
            cfg_done   <= (state_d == DONE);
            // Only a complete mask ever reaches the shared sel bus.
            if (state_q == SHIFT && state_d == SETUP) begin
                term_sel <= shift_d;
            end
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Scoreboard bench for pal_cfg_loader: directed streams, expected strobes queued,
// a negedge monitor pops and compares each strobe and done pulse.
module tb_pal_cfg_loader;

    localparam int NI = 5;
    localparam int NT = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [NI-1:0] term_sel;
    logic [NT-1:0] term_wen;
    logic          busy;
    logic          cfg_done;

    pal_cfg_loader #(.NUM_INPUTS(NI), .NUM_TERMS(NT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .term_sel  (term_sel),
        .term_wen  (term_wen),
        .busy      (busy),
        .cfg_done  (cfg_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NT-1:0] wen;
        logic [NI-1:0] sel;
    } strobe_t;

    strobe_t exp_q[$];
    int      done_q[$];   // expected start-to-done edge count, -1 = not timed
    int      tests = 0;
    int      fails = 0;
    int      edge_cnt = 0;
    int      start_edge = 0;

    // Masks 01101/10010/11111/11000, i.e. streams 10110 01001 11111 00011 sent LSB first.
    localparam logic [NI-1:0] M0 = 5'b01101;
    localparam logic [NI-1:0] M1 = 5'b10010;
    localparam logic [NI-1:0] M2 = 5'b11111;
    localparam logic [NI-1:0] M3 = 5'b11000;
    localparam logic [4*NI-1:0] STREAM = {M3, M2, M1, M0};

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    logic [NI-1:0] prev_sel = '0;
    logic [NT-1:0] prev_wen = '0;
    logic          prev_rst = 1'b0;
    logic          prev_done = 1'b0;

    always @(negedge clk) begin
        strobe_t e;
        int      lat;
        if (rst_n && prev_rst) begin
            if (term_wen != '0 && prev_wen == '0) chk("sel_setup", term_sel, prev_sel);
            if (term_wen == '0 && prev_wen != '0) chk("sel_hold", term_sel, prev_sel);
            if (prev_done && !cfg_done) chk("busy_fall", busy, 0);
        end
        if (term_wen != '0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", term_wen, 0);
            end else begin
                e = exp_q.pop_front();
                chk("strobe_wen", term_wen, e.wen);
                chk("strobe_sel", term_sel, e.sel);
            end
        end
        if (cfg_done) begin
            chk("done_busy", busy, 1);
            if (done_q.size() == 0) begin
                chk("unexpected_done", cfg_done, 0);
            end else begin
                lat = done_q.pop_front();
                if (lat >= 0) chk("done_latency", edge_cnt - start_edge, lat);
            end
        end
        prev_sel  = term_sel;
        prev_wen  = term_wen;
        prev_rst  = rst_n;
        prev_done = cfg_done;
    end

    task automatic push_terms(input int n);
        strobe_t s;
        for (int k = 0; k < n; k++) begin
            s.wen = NT'(1) << k;
            s.sel = STREAM[k*NI +: NI];
            exp_q.push_back(s);
        end
    endtask

    task automatic start_session();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        start_edge = edge_cnt;
    endtask

    // Presents bits from the current negedge; a beat counts when valid and ready are both high.
    task automatic stream(input int nbits, input bit toggle);
        int idx = 0;
        int cyc = 0;
        while (idx < nbits && cyc < 300) begin
            cfg_valid = toggle ? ~cyc[0] : 1'b1;
            cfg_bit   = STREAM[idx];
            if (cfg_valid && cfg_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        cfg_valid = 1'b0;
        if (idx < nbits) chk("stream_timeout", idx, nbits);
    endtask

    task automatic wait_drained();
        int n = 0;
        while ((busy || exp_q.size() != 0 || done_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("session_drained", exp_q.size() + done_q.size(), 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        // Reset values
        #3;
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wen", term_wen, 0);
        chk("rst_sel", term_sel, 0);
        chk("rst_done", cfg_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", cfg_ready, 0);

        // Basic session, valid held high: cfg_done is the 34th cycle counting the
        // start cycle, i.e. 32 edges after the edge that samples cfg_start.
        push_terms(4);
        done_q.push_back(32);
        start_session();
        stream(20, 1'b0);
        wait_drained();
        chk("sel_retained", term_sel, M3);

        // Valid toggling 1,0,1,0
        push_terms(4);
        done_q.push_back(-1);
        start_session();
        stream(20, 1'b1);
        wait_drained();

        // cfg_start pulsed during STROBE of term 1 is ignored
        push_terms(4);
        done_q.push_back(32);
        start_session();
        fork
            stream(20, 1'b0);
            begin
                int n = 0;
                while (term_wen !== 4'b0010 && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                chk("probe_strobe1", term_wen, 4'b0010);
                cfg_start = 1'b1;
                @(negedge clk);
                cfg_start = 1'b0;
            end
        join
        wait_drained();
        repeat (3) @(negedge clk);
        chk("start_ignored", busy, 0);

        // Reset after 3 bits of term 2: terms 0 and 1 strobed, term 2 never
        push_terms(2);
        start_session();
        stream(13, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_wen", term_wen, 0);
        chk("arst_ready", cfg_ready, 0);
        chk("arst_sel", term_sel, 0);
        chk("arst_done", cfg_done, 0);
        chk("arst_strobes", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", busy, 0);

        // Fresh session after reset
        push_terms(4);
        done_q.push_back(32);
        start_session();
        stream(20, 1'b0);
        wait_drained();
        chk("final_sel", term_sel, M3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
